// File: rtl/muldiv_sequencer_if.sv
// Bundle between the MIPS control unit / iterative mult-div units and the sequencer.
// No latency of its own; pure wiring.
// The sequencer exposes busy; the environment holds off new requests while it is high.
interface muldiv_sequencer_if;
  // Request side from main control
  logic        start;
  logic [1:0]  op;
  logic [31:0] divisor;
  logic [31:0] wdata;
  // Iterative unit results
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  // Sequencer controls and architectural state
  logic        unit_clear;
  logic        mult_en;
  logic        div_en;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  // Environment side: control unit plus the two iterative units
  modport master (
    output start, op, divisor, wdata, mult_hi, mult_lo, div_hi, div_lo,
    input  unit_clear, mult_en, div_en, hi, lo, busy, done, div_zero
  );

  // Sequencer side
  modport slave (
    input  start, op, divisor, wdata, mult_hi, mult_lo, div_hi, div_lo,
    output unit_clear, mult_en, div_en, hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences iterative MIPS mult/div units (clear, enable N cycles, capture) and owns HI/LO.
// Latency: MULT/DIV result and done N+3 cycles after start; MTHI/MTLO and trapped div-by-zero 1 cycle.
// Backpressure: busy high CLEAR..CAPTURE, start outside IDLE dropped; MULDIV_DIV_ZERO_TRAP_EN enables zero trap.
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             accept;
  logic             run_last;
  logic             div_trap;

`ifdef MULDIV_DIV_ZERO_TRAP_EN
  // A zero divisor is caught in IDLE; the divide unit never starts.
  assign div_trap = (bus.divisor == 32'd0);
`else
  // Without the trap the divisor is never inspected; the unit produces whatever it produces.
  logic unused_divisor;
  assign unused_divisor = |bus.divisor;
  assign div_trap       = 1'b0;
`endif

  assign accept   = (state_q == S_IDLE) && bus.start;
  assign run_last = is_div_q ? (cnt_q == CNT_W'(DIV_CYCLES - 1))
                             : (cnt_q == CNT_W'(MULT_CYCLES - 1));

  // State register: reset aborts any operation at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: MULT/DIV walk CLEAR -> RUN (N cycles) -> CAPTURE; moves and traps stay in IDLE
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && (bus.op == OP_MULT || (bus.op == OP_DIV && !div_trap))) begin
          state_d  = S_CLEAR;
          is_div_d = (bus.op == OP_DIV);
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (run_last) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register so a reset drops the enables without waiting for a clock
  always_comb begin
    bus.unit_clear = (state_q == S_CLEAR);
    bus.mult_en    = (state_q == S_RUN) && !is_div_q;
    bus.div_en     = (state_q == S_RUN) && is_div_q;
    bus.busy       = (state_q != S_IDLE);
  end

  // HI/LO and pulse next values: moves write immediately, CAPTURE commits the selected unit
  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    if (accept) begin
      unique case (bus.op)
        OP_MTHI: begin
          hi_d   = bus.wdata;
          done_d = 1'b1;
        end
        OP_MTLO: begin
          lo_d   = bus.wdata;
          done_d = 1'b1;
        end
        OP_DIV: begin
          if (div_trap) begin
            div_zero_d = 1'b1;
            done_d     = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end else if (state_q == S_CAPTURE) begin
      hi_d   = is_div_q ? bus.div_hi : bus.mult_hi;
      lo_d   = is_div_q ? bus.div_lo : bus.mult_lo;
      done_d = 1'b1;
    end
  end

  // Architectural HI/LO and registered completion pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus hand-written multi-cycle sequences.
// Cycle k counts clock periods after the edge that sampled start (cycle 1 follows that edge).
// Unit model is a set of constant result values chosen per vector.
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;
  localparam int         N       = 32;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(
    .MULT_CYCLES (N),
    .DIV_CYCLES  (N),
    .CNT_W       (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] divisor;
    logic [31:0] wdata;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] d_hi;
    logic [31:0] d_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
    int          exp_clr;
    int          exp_men;
    int          exp_den;
    int          exp_busy;
    int          exp_dz;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_units(input logic [31:0] mh, input logic [31:0] ml,
                           input logic [31:0] dh, input logic [31:0] dl);
    bus.mult_hi = mh;
    bus.mult_lo = ml;
    bus.div_hi  = dh;
    bus.div_lo  = dl;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] divisor, input logic [31:0] wdata);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.divisor = divisor;
    bus.wdata   = wdata;
  endtask

  // Runs until done (bounded); optionally injects a one-cycle start at cycle inj_cycle
  task automatic monitor(input int inj_cycle, input logic [1:0] inj_op,
                         output int lat, output int clr, output int men,
                         output int den, output int bsy, output int dz);
    lat = 0; clr = 0; men = 0; den = 0; bsy = 0; dz = 0;
    do begin
      tick();
      lat++;
      bus.start = 1'b0;
      if (bus.unit_clear) clr++;
      if (bus.mult_en)    men++;
      if (bus.div_en)     den++;
      if (bus.busy)       bsy++;
      if (bus.div_zero)   dz++;
      if (lat == inj_cycle) begin
        bus.start = 1'b1;
        bus.op    = inj_op;
      end
    end while (!bus.done && lat < 200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, clr, men, den, bsy, dz;
    n_pass  = 0;
    n_total = 0;

    // name, op, divisor, wdata, m_hi, m_lo, d_hi, d_lo, exp_hi, exp_lo, lat, clr, men, den, busy, dz
    vecs[0] = '{"mult_neg3x2", OP_MULT, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0, 32'h0,
                32'hFFFF_FFFF, 32'hFFFF_FFFA, N+3, 1, N, 0, N+2, 0};
    vecs[1] = '{"div_23by3", OP_DIV, 32'd3, 32'd0, 32'h1111_1111, 32'h2222_2222, 32'd2, 32'd7,
                32'd2, 32'd7, N+3, 1, 0, N, N+2, 0};
    vecs[2] = '{"mthi", OP_MTHI, 32'd0, 32'hAAAA_0001, 32'h1, 32'h2, 32'h3, 32'h4,
                32'hAAAA_0001, 32'd7, 1, 0, 0, 0, 0, 0};
    vecs[3] = '{"mtlo", OP_MTLO, 32'd0, 32'h0000_5555, 32'h1, 32'h2, 32'h3, 32'h4,
                32'hAAAA_0001, 32'h0000_5555, 1, 0, 0, 0, 0, 0};
`ifdef MULDIV_DIV_ZERO_TRAP_EN
    vecs[4] = '{"div_by_zero", OP_DIV, 32'd0, 32'd0, 32'h0, 32'h0, 32'h0BAD_0000, 32'h0000_0BAD,
                32'hAAAA_0001, 32'h0000_5555, 1, 0, 0, 0, 0, 1};
`else
    vecs[4] = '{"div_by_zero", OP_DIV, 32'd0, 32'd0, 32'h0, 32'h0, 32'h0BAD_0000, 32'h0000_0BAD,
                32'h0BAD_0000, 32'h0000_0BAD, N+3, 1, 0, N, N+2, 0};
`endif
    vecs[5] = '{"mult_zero_divisor", OP_MULT, 32'd0, 32'd0, 32'h0000_0001, 32'h8000_0000,
                32'h0BAD_0000, 32'h0000_0BAD, 32'h0000_0001, 32'h8000_0000, N+3, 1, N, 0, N+2, 0};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OP_MULT;
    bus.divisor = 32'd0;
    bus.wdata   = 32'd0;
    set_units(32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst.hi", bus.hi, 32'h0);
    check("rst.lo", bus.lo, 32'h0);
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.done", {31'd0, bus.done}, 32'd0);
    check("rst.clear", {31'd0, bus.unit_clear}, 32'd0);
    check("rst.en", {30'd0, bus.mult_en, bus.div_en}, 32'd0);
    check("rst.div_zero", {31'd0, bus.div_zero}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      set_units(vecs[i].m_hi, vecs[i].m_lo, vecs[i].d_hi, vecs[i].d_lo);
      issue(vecs[i].op, vecs[i].divisor, vecs[i].wdata);
      monitor(0, OP_MULT, lat, clr, men, den, bsy, dz);
      check($sformatf("%s.latency", vecs[i].name), lat, vecs[i].exp_lat);
      check($sformatf("%s.clear_cycles", vecs[i].name), clr, vecs[i].exp_clr);
      check($sformatf("%s.mult_en_cycles", vecs[i].name), men, vecs[i].exp_men);
      check($sformatf("%s.div_en_cycles", vecs[i].name), den, vecs[i].exp_den);
      check($sformatf("%s.busy_cycles", vecs[i].name), bsy, vecs[i].exp_busy);
      check($sformatf("%s.div_zero_pulses", vecs[i].name), dz, vecs[i].exp_dz);
      check($sformatf("%s.hi", vecs[i].name), bus.hi, vecs[i].exp_hi);
      check($sformatf("%s.lo", vecs[i].name), bus.lo, vecs[i].exp_lo);
      tick();
      check($sformatf("%s.done_one_cycle", vecs[i].name), {31'd0, bus.done}, 32'd0);
    end

    // Back-to-back: MULT issued in the DIV done cycle is accepted with no gap
    set_units(32'h0000_000A, 32'h0000_000B, 32'd2, 32'd7);
    issue(OP_DIV, 32'd3, 32'd0);
    monitor(0, OP_MULT, lat, clr, men, den, bsy, dz);
    check("b2b.div_latency", lat, N+3);
    check("b2b.div_hi", bus.hi, 32'd2);
    check("b2b.div_lo", bus.lo, 32'd7);
    issue(OP_MULT, 32'd0, 32'd0);
    monitor(0, OP_MULT, lat, clr, men, den, bsy, dz);
    check("b2b.mult_latency", lat, N+3);
    check("b2b.mult_en_cycles", men, N);
    check("b2b.mult_hi", bus.hi, 32'h0000_000A);
    check("b2b.mult_lo", bus.lo, 32'h0000_000B);
    tick();

    // MULT start during a DIV RUN is ignored
    set_units(32'h5555_5555, 32'h6666_6666, 32'd4, 32'd9);
    issue(OP_DIV, 32'd2, 32'd0);
    monitor(10, OP_MULT, lat, clr, men, den, bsy, dz);
    check("ignore.latency", lat, N+3);
    check("ignore.mult_en_cycles", men, 0);
    check("ignore.div_en_cycles", den, N);
    check("ignore.hi", bus.hi, 32'd4);
    check("ignore.lo", bus.lo, 32'd9);
    tick();
    check("ignore.no_restart", {31'd0, bus.busy}, 32'd0);

    // MTHI then MTLO on consecutive cycles
    issue(OP_MTHI, 32'd0, 32'h1234_5678);
    tick();
    check("mtmt.done1", {31'd0, bus.done}, 32'd1);
    check("mtmt.hi1", bus.hi, 32'h1234_5678);
    check("mtmt.busy1", {31'd0, bus.busy}, 32'd0);
    issue(OP_MTLO, 32'd0, 32'hDEAD_BEEF);
    tick();
    bus.start = 1'b0;
    check("mtmt.done2", {31'd0, bus.done}, 32'd1);
    check("mtmt.hi2", bus.hi, 32'h1234_5678);
    check("mtmt.lo2", bus.lo, 32'hDEAD_BEEF);
    check("mtmt.busy2", {31'd0, bus.busy}, 32'd0);
    tick();
    check("mtmt.done_clear", {31'd0, bus.done}, 32'd0);

    // Reset during RUN at counter 10 aborts at once
    set_units(32'h0000_0003, 32'h0000_0004, 32'h0, 32'h0);
    issue(OP_MULT, 32'd0, 32'd0);
    tick();
    bus.start = 1'b0;
    check("rstrun.clear_cycle1", {31'd0, bus.unit_clear}, 32'd1);
    repeat (11) tick();
    check("rstrun.mult_en_before", {31'd0, bus.mult_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstrun.mult_en_async", {31'd0, bus.mult_en}, 32'd0);
    check("rstrun.hi", bus.hi, 32'h0);
    check("rstrun.lo", bus.lo, 32'h0);
    check("rstrun.busy", {31'd0, bus.busy}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    issue(OP_MULT, 32'd0, 32'd0);
    monitor(0, OP_MULT, lat, clr, men, den, bsy, dz);
    check("rstrun.next_latency", lat, N+3);
    check("rstrun.next_mult_en_cycles", men, N);
    check("rstrun.next_hi", bus.hi, 32'h0000_0003);
    check("rstrun.next_lo", bus.lo, 32'h0000_0004);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the multicycle MIPS multiply/divide path. It accepts MULT, DIV, MTHI and MTLO requests from the main control unit and sequences the iterative multiply and divide units: clear, enable for a fixed iteration count, then capture. It owns the architectural HI/LO registers and holds `busy` so control stalls any MFHI/MFLO or new mult/div request until the result is committed.

## Interface
Parameters:
- `MULT_CYCLES`, default 32: number of cycles `mult_en` is held high.
- `DIV_CYCLES`, default 32: number of cycles `div_en` is held high.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: request strobe; sampled only in IDLE.
- `op`  in  2: request code. 00 = MULT, 01 = DIV, 10 = MTHI, 11 = MTLO.
- `divisor`  in  32: divisor value, checked against zero when `start` is high.
- `wdata`  in  32: source value for MTHI/MTLO, sampled with `start`.
- `mult_hi`, `mult_lo`  in  32 each: multiply unit result.
- `div_hi`, `div_lo`  in  32 each: divide unit result (remainder, quotient).
- `unit_clear`  out  1: one-cycle clear to both iterative units.
- `mult_en`  out  1: multiply unit iteration enable.
- `div_en`  out  1: divide unit iteration enable.
- `hi`, `lo`  out  32 each: architectural HI/LO registers.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle completion pulse.
- `div_zero`  out  1: one-cycle divide-by-zero pulse.

## Operation
- Reset values: state IDLE, counter 0, `hi`/`lo` 0, and all 1-bit outputs 0. Reset mid-operation aborts immediately. Enables drop asynchronously. HI/LO return to 0.
- States: IDLE, CLEAR, RUN, CAPTURE.
- IDLE with `start`=1:
  - MULT or DIV: latch `op`, go to CLEAR, set `busy`.
  - MTHI or MTLO: write `wdata` to `hi` or `lo` on that edge. Pulse `done` the next cycle. No state change, `busy` stays 0.
  - DIV with `divisor`==0 (see Configuration): pulse `div_zero` and `done` the next cycle. HI/LO unchanged, stay in IDLE.
- CLEAR: `unit_clear`=1 for exactly one cycle, counter cleared, then go to RUN.
- RUN: assert `mult_en` (MULT) or `div_en` (DIV), never both. The counter increments each cycle. After N cycles (N = MULT_CYCLES or DIV_CYCLES), go to CAPTURE.
- CAPTURE: enables low, unit outputs stable. On exit, `hi`/`lo` load from the selected unit's outputs. Next state IDLE.
- `done` is a registered pulse, high for exactly the first cycle in which new HI/LO values are visible. `busy` is low in that same cycle.
- `start` outside IDLE is ignored: no queuing, no error flag.
- `op`, `divisor` and `wdata` are don't-care when `start`=0.

## Timing
- Edge E0 samples `start` (MULT/DIV).
- CLEAR occupies the cycle after E0.
- RUN occupies the next N cycles.
- CAPTURE occupies one cycle.
- HI/LO update and `done` appear N+3 edges after E0. Default MULT: 35 edges.
- `busy` is high from E0+1 through the CAPTURE cycle.
- Back-to-back: `start` in the `done` cycle is accepted. Minimum issue interval is N+3 cycles.
- MTHI/MTLO: `hi`/`lo` update on E0+1; `done` high in cycle E0+1.
- Divide-by-zero: `div_zero` and `done` high in cycle E0+1.

## Configuration
- `MULDIV_DIV_ZERO_TRAP_EN` defined:
  - DIV with `divisor`==0 is trapped in IDLE and never enables the divide unit.
  - `div_zero` pulses and HI/LO keep their previous values.
- Not defined:
  - No zero check is made; the divide runs the full DIV_CYCLES and HI/LO take whatever the divide unit produces.
  - `div_zero` is tied to 0.

## Test plan
- Reset during RUN at counter 10: enables drop within the same cycle. `hi`=`lo`=0, `busy`=0. Next MULT completes normally in 35 cycles.
- MULT with a unit model returning hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA (-3 × 2): check `unit_clear` high 1 cycle, `mult_en` high exactly 32 cycles, `done` at edge 35, `hi`/`lo` match the model.
- DIV with unit model quotient 7, remainder 2 (23/3), then `start` MULT in the `done` cycle: `lo`=7, `hi`=2. Second op is accepted with zero gap.
- `start` MULT during RUN of a DIV: ignored. `mult_en` never asserts, and DIV result is committed unchanged.
- MTHI `wdata`=32'h1234_5678, then MTLO `wdata`=32'hDEAD_BEEF on consecutive cycles: `hi`/`lo` hold those values, two `done` pulses, `busy` never high.
- DIV with `divisor`=0, with and without `MULDIV_DIV_ZERO_TRAP_EN`:
  - With the macro: `div_zero` pulses at E0+1 and HI/LO are unchanged.
  - Without it: `div_en` runs 32 cycles and `div_zero` stays 0.
